hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the ID stage of the five-stage pipeline, replacing single-cycle load-use detection with a per-register countdown scoreboard. It handles configurable load latency and multi-cycle (long) ops, and squashes scoreboard entries belonging to flushed instructions on a MEM-stage redirect. It drives the PC and IF/ID write enables and the IF/ID, ID/EX and EX/MEM flushes, and keeps stall and flush performance counters.

## Interface
- NUM_REGS, 32, architectural registers; register 0 is hard-wired and never tracked
- REG_AW, 5, register index width, equal to clog2(NUM_REGS)
- LOAD_LAT, 1, bubbles a consumer waits behind a load; legal range 1..2
- LONG_LAT, 4, bubbles a consumer waits behind a long op (mul/div); legal range 1..15
- CNT_W, 32, performance counter width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  REG_AW  source registers of the ID instruction
- id_uses_rs_i, id_uses_rt_i  in  1  the source is actually read
- id_wr_en_i  in  1  the ID instruction writes a register
- id_wr_reg_i  in  REG_AW  destination register
- id_is_load_i, id_is_long_i  in  1  instruction class; both set is illegal
- redirect_i  in  1  taken branch or jump resolved in MEM
- pc_write_o, ifid_write_o  out  1  enables, low during a stall
- ifid_flush_o, idex_flush_o, exmem_flush_o  out  1  stage flushes
- stall_o  out  1  data-hazard stall this cycle
- stall_cycles_o, flush_events_o  out  CNT_W  performance counters, wrapping

## Operation
- Scoreboard: one counter per register 1..NUM_REGS-1. Value = cycles a consumer in ID must still wait. 0 = free.
- Hazard: stall_o = id_valid_i & !redirect_i & ((id_uses_rs_i & cnt[id_rs_i]≠0) | (id_uses_rt_i & cnt[id_rt_i]≠0)). Reads of register 0 never stall.
- Redirect takes priority over a stall:
  - ifid_flush_o = idex_flush_o = exmem_flush_o = 1
  - pc_write_o = ifid_write_o = 1
  - stall_o = 0
- Stall without redirect:
  - pc_write_o = ifid_write_o = 0
  - idex_flush_o = 1, which inserts a bubble
  - the other flushes stay 0
- Issue: issue = id_valid_i & !stall_o & !redirect_i. On issue with id_wr_en_i and id_wr_reg_i≠0, the destination counter loads LOAD_LAT for a load, LONG_LAT for a long op, and 0 otherwise (the result is forwarded). The new value overrides any pending value (WAW: the younger write wins).
- Decrement: every cycle, each nonzero counter not being loaded decrements by 1.
- Squash history: a 2-deep shift register records (valid, reg) for the instructions now in ID/EX and EX/MEM. It shifts on every clock, entering a bubble when nothing issues. On redirect, both recorded registers' counters clear to 0 and the history clears. Counters of older instructions (MEM/WB) are untouched.
- Performance counters: stall_cycles_o increments in each cycle with stall_o = 1. flush_events_o increments in each cycle with redirect_i = 1.

## Timing
- Control outputs are combinational from registered counters and the current ID and redirect inputs. There is no added latency.
- With LOAD_LAT = 1, a load followed by a dependent instruction gives exactly 1 bubble. LONG_LAT = N gives N bubbles.
- The scoreboard load, decrement and history shift all take effect at the same edge as the issue.
- Reset (asynchronous, any cycle, including mid-stall):
  - all counters, history and performance counters go to 0
  - with rst_i high and redirect_i low: pc_write_o = 1, ifid_write_o = 1, all flushes 0, stall_o = 0
- Redirect and hazard in the same cycle: the redirect wins and the ID instruction is not issued.
- Redirect in consecutive cycles: each one clears the current history entries.

## Structure
- Shared package hazard_pkg:
  - clog2 function
  - counter width SB_W = clog2(max(LOAD_LAT, LONG_LAT)+1)
  - instruction-class encoding
- One natural sub-module, hazard_sb_entry: a single register counter with load, decrement and clear ports. It is instantiated per register with a generate loop.
- Top level: source-index read muxes, hazard and priority logic, squash history, performance counters.

## Test plan
- Load r8, then add r9 = r8 + r1 (LOAD_LAT = 1) → one cycle with stall_o = 1, pc_write_o = 0, idex_flush_o = 1; stall_cycles_o = 1.
- Long op writing r5 (LONG_LAT = 4), then a consumer of r5 → exactly 4 stall cycles, then issue.
- Load r8 issued, then redirect_i pulsed the next cycle → all three flushes 1; cnt[r8] cleared; the next consumer of r8 does not stall; flush_events_o = 1.
- Redirect while a consumer is stalled on r5 → stall_o = 0, pc_write_o = 1, all flushes 1.
- Load writing r0, then a consumer of r0 → no stall. Load r7 then ALU write r7 → the consumer of r7 does not stall (WAW override).
- rst_i asserted mid long-op stall (cnt = 2) → all counters 0 immediately; after release the consumer issues with no stall; performance counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and elaboration-time helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2
  } instr_class_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter width able to hold the larger of the two producer latencies.
  function automatic int unsigned sb_width(input int unsigned load_lat,
                                           input int unsigned long_lat);
    return clog2(((load_lat > long_lat) ? load_lat : long_lat) + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: cycles a consumer of this register must still wait.
module hazard_sb_entry #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  output logic         o_busy
);

  logic [W-1:0] r_cnt;

  // Clear beats load beats countdown; a load overrides any pending value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard, redirect squash,
// pipeline enable/flush control and stall/flush performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned LONG_LAT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_wr_en_i,
  input  logic [REG_AW-1:0] id_wr_reg_i,
  input  logic              id_is_load_i,
  input  logic              id_is_long_i,
  input  logic              redirect_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_events_o
);

  localparam int unsigned SB_W = sb_width(LOAD_LAT, LONG_LAT);

  logic [NUM_REGS-1:0] w_busy;
  logic                w_rs_haz;
  logic                w_rt_haz;
  logic                w_stall;
  logic                w_issue;
  logic                w_sb_wr;
  instr_class_e        w_cls;
  logic [SB_W-1:0]     w_load_val;

  // History of destination registers now in ID/EX (h0) and EX/MEM (h1).
  logic                r_h0_vld;
  logic                r_h1_vld;
  logic [REG_AW-1:0]   r_h0_reg;
  logic [REG_AW-1:0]   r_h1_reg;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // Register 0 is hard-wired, so it is never busy.
  assign w_busy[0] = 1'b0;

  generate
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
      logic w_ld;
      logic w_clr;
      assign w_ld  = w_sb_wr && (id_wr_reg_i == REG_AW'(g));
      assign w_clr = redirect_i &&
                     ((r_h0_vld && (r_h0_reg == REG_AW'(g))) ||
                      (r_h1_vld && (r_h1_reg == REG_AW'(g))));
      hazard_sb_entry #(.W(SB_W)) u_entry (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_ld),
        .i_load_val (w_load_val),
        .i_clr      (w_clr),
        .o_busy     (w_busy[g])
      );
    end
  endgenerate

  assign w_rs_haz = id_uses_rs_i && w_busy[id_rs_i];
  assign w_rt_haz = id_uses_rt_i && w_busy[id_rt_i];
  assign w_stall  = id_valid_i && !redirect_i && (w_rs_haz || w_rt_haz);
  assign w_issue  = id_valid_i && !w_stall && !redirect_i;
  assign w_sb_wr  = w_issue && id_wr_en_i && (id_wr_reg_i != '0);

  // Classify the ID instruction; load takes precedence if both flags are set.
  always_comb begin
    w_cls = CLS_ALU;
    if (id_is_load_i)      w_cls = CLS_LOAD;
    else if (id_is_long_i) w_cls = CLS_LONG;
  end

  // Wait count seeded into the destination entry; ALU results are forwarded.
  always_comb begin
    w_load_val = '0;
    case (w_cls)
      CLS_LOAD: w_load_val = SB_W'(LOAD_LAT);
      CLS_LONG: w_load_val = SB_W'(LONG_LAT);
      default:  w_load_val = '0;
    endcase
  end

  // Squash history: shifts every edge, bubble when nothing issues, cleared on redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h0_vld <= 1'b0;
      r_h1_vld <= 1'b0;
      r_h0_reg <= '0;
      r_h1_reg <= '0;
    end else if (redirect_i) begin
      r_h0_vld <= 1'b0;
      r_h1_vld <= 1'b0;
      r_h0_reg <= '0;
      r_h1_reg <= '0;
    end else begin
      r_h1_vld <= r_h0_vld;
      r_h1_reg <= r_h0_reg;
      r_h0_vld <= w_sb_wr;
      r_h0_reg <= id_wr_reg_i;
    end
  end

  // Wrapping performance counters for stall cycles and redirect events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (redirect_i) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_o        = w_stall;
  assign pc_write_o     = !w_stall;
  assign ifid_write_o   = !w_stall;
  assign ifid_flush_o   = redirect_i;
  assign idex_flush_o   = redirect_i || w_stall;
  assign exmem_flush_o  = redirect_i;
  assign stall_cycles_o = r_stall_cnt;
  assign flush_events_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  localparam int LOAD_LAT = 1;
  localparam int LONG_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs_i = '0;
  logic [4:0]  id_rt_i = '0;
  logic        id_uses_rs_i = 1'b0;
  logic        id_uses_rt_i = 1'b0;
  logic        id_wr_en_i = 1'b0;
  logic [4:0]  id_wr_reg_i = '0;
  logic        id_is_load_i = 1'b0;
  logic        id_is_long_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o, stall_o;
  logic [31:0] stall_cycles_o, flush_events_o;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS (32),
    .REG_AW   (5),
    .LOAD_LAT (LOAD_LAT),
    .LONG_LAT (LONG_LAT),
    .CNT_W    (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rs_i   (id_uses_rs_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .id_wr_en_i     (id_wr_en_i),
    .id_wr_reg_i    (id_wr_reg_i),
    .id_is_load_i   (id_is_load_i),
    .id_is_long_i   (id_is_long_i),
    .redirect_i     (redirect_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_flush_o  (exmem_flush_o),
    .stall_o        (stall_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_events_o (flush_events_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining wait per register, two in-flight writers, counters.
  int          m_cnt [32];
  bit          m_hv  [2];
  int          m_hr  [2];
  int unsigned m_stalls;
  int unsigned m_flushes;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_hv[0] = 0; m_hv[1] = 0;
    m_hr[0] = 0; m_hr[1] = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  // Compare process: every falling edge, check outputs then advance the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst_i) begin
        model_reset();
        chk("rst_pc_write", 32'(pc_write_o), 32'(!redirect_i));
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_stall_cycles", stall_cycles_o, 32'd0);
        chk("rst_flush_events", flush_events_o, 32'd0);
      end else begin
        bit e_stall, e_issue, e_write;
        int nc [32];
        int rs, rt, wr;
        rs = int'(id_rs_i);
        rt = int'(id_rt_i);
        wr = int'(id_wr_reg_i);
        e_stall = id_valid_i && !redirect_i &&
                  ((id_uses_rs_i && rs != 0 && m_cnt[rs] > 0) ||
                   (id_uses_rt_i && rt != 0 && m_cnt[rt] > 0));
        e_issue = id_valid_i && !e_stall && !redirect_i;
        e_write = e_issue && id_wr_en_i && wr != 0;

        chk("stall", 32'(stall_o), 32'(e_stall));
        chk("pc_write", 32'(pc_write_o), 32'(!e_stall));
        chk("ifid_write", 32'(ifid_write_o), 32'(!e_stall));
        chk("ifid_flush", 32'(ifid_flush_o), 32'(redirect_i));
        chk("idex_flush", 32'(idex_flush_o), 32'(redirect_i || e_stall));
        chk("exmem_flush", 32'(exmem_flush_o), 32'(redirect_i));
        chk("stall_cycles", stall_cycles_o, m_stalls);
        chk("flush_events", flush_events_o, m_flushes);

        for (int r = 0; r < 32; r++) nc[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
        if (redirect_i) begin
          for (int k = 0; k < 2; k++) if (m_hv[k]) nc[m_hr[k]] = 0;
          m_hv[0] = 0; m_hv[1] = 0;
        end else begin
          m_hv[1] = m_hv[0]; m_hr[1] = m_hr[0];
          m_hv[0] = e_write; m_hr[0] = wr;
        end
        if (e_write) nc[wr] = id_is_load_i ? LOAD_LAT : (id_is_long_i ? LONG_LAT : 0);
        for (int r = 0; r < 32; r++) m_cnt[r] = nc[r];
        if (e_stall) m_stalls++;
        if (redirect_i) m_flushes++;
      end
    end
  end

  task automatic set_in(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit wen, input int wr, input bit ld, input bit lg, input bit rd);
    id_valid_i   = v;
    id_rs_i      = 5'(rs);
    id_uses_rs_i = urs;
    id_rt_i      = 5'(rt);
    id_uses_rt_i = urt;
    id_wr_en_i   = wen;
    id_wr_reg_i  = 5'(wr);
    id_is_load_i = ld;
    id_is_long_i = lg;
    redirect_i   = rd;
  endtask

  // Drive one ID cycle and wait until outputs are settled mid-cycle.
  task automatic go(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                    input bit wen, input int wr, input bit ld, input bit lg, input bit rd);
    set_in(v, rs, urs, rt, urt, wen, wr, ld, lg, rd);
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt();
    end
  endtask

  int nst;

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset_pc_write", 32'(pc_write_o), 32'd1);
    chk("reset_ifid_write", 32'(ifid_write_o), 32'd1);
    chk("reset_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Load r8 then r9 = r8 + r1: one bubble
    go(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    chk("load_issue_stall", 32'(stall_o), 32'd0);
    nxt();
    go(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    chk("lu_stall", 32'(stall_o), 32'd1);
    chk("lu_pc_write", 32'(pc_write_o), 32'd0);
    chk("lu_idex_flush", 32'(idex_flush_o), 32'd1);
    chk("lu_ifid_flush", 32'(ifid_flush_o), 32'd0);
    nxt();
    go(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    chk("lu_second_try", 32'(stall_o), 32'd0);
    chk("lu_stall_cycles", stall_cycles_o, 32'd1);
    nxt();
    idle(2);

    // Long op r5 then consumer: exactly LONG_LAT bubbles
    go(1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    nxt();
    nst = 0;
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    while (stall_o && nst < 10) begin
      nst++;
      nxt();
      go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("long_bubbles", nst, 32'd4);
    chk("long_stall_cycles", stall_cycles_o, 32'd5);
    nxt();
    idle(2);

    // Long r5 issued, redirect next cycle squashes it
    go(1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    nxt();
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("redir_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 32'd7);
    chk("redir_pc_write", 32'(pc_write_o), 32'd1);
    nxt();
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("squash_no_stall", 32'(stall_o), 32'd0);
    chk("flush_events_1", flush_events_o, 32'd1);
    nxt();

    // Two in-flight long ops both squashed
    go(1, 0, 0, 0, 0, 1, 6, 0, 1, 0); nxt();
    go(1, 0, 0, 0, 0, 1, 7, 0, 1, 0); nxt();
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); nxt();
    go(1, 6, 1, 7, 1, 0, 0, 0, 0, 0);
    chk("squash_both_entries", 32'(stall_o), 32'd0);
    nxt();

    // Redirect while a consumer is stalled
    go(1, 0, 0, 0, 0, 1, 5, 0, 1, 0); nxt();
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_redir_stall", 32'(stall_o), 32'd1);
    nxt();
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("redir_over_stall", 32'(stall_o), 32'd0);
    chk("redir_over_stall_pc", 32'(pc_write_o), 32'd1);
    chk("redir_over_stall_fl", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 32'd7);
    nxt();
    idle(5);

    // Writes to r0 are never tracked
    go(1, 0, 0, 0, 0, 1, 0, 0, 1, 0); nxt();
    go(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("r0_no_stall", 32'(stall_o), 32'd0);
    nxt();

    // WAW: younger ALU write to r7 overrides the long-op wait
    go(1, 0, 0, 0, 0, 1, 7, 0, 1, 0); nxt();
    go(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); nxt();
    go(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_no_stall", 32'(stall_o), 32'd0);
    nxt();
    idle(5);

    // Asynchronous reset in the middle of a long-op stall
    go(1, 0, 0, 0, 0, 1, 5, 0, 1, 0); nxt();
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); nxt();
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_stall", 32'(stall_o), 32'd1);
    nxt();
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_stall", 32'(stall_o), 32'd0);
    chk("async_rst_pc_write", 32'(pc_write_o), 32'd1);
    chk("async_rst_stall_cycles", stall_cycles_o, 32'd0);
    chk("async_rst_flush_events", flush_events_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    go(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_issue", 32'(stall_o), 32'd0);
    nxt();

    // Randomized traffic against the model
    repeat (2000) begin
      int c;
      c = $urandom_range(0, 3);
      go($urandom_range(0, 9) < 8,
         $urandom_range(0, 7), $urandom_range(0, 1) == 1,
         $urandom_range(0, 7), $urandom_range(0, 1) == 1,
         $urandom_range(0, 3) != 0, $urandom_range(0, 7),
         c == 1, c == 2,
         $urandom_range(0, 99) < 8);
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
